// File: rtl/bus_initiator_pkg.sv
// Shared types for the single-outstanding bus initiator.
// These cover the FSM state encoding and the latched command that drives the bus.
package bus_initiator_pkg;

  typedef enum logic [1:0] {
    BI_IDLE,
    BI_REQ,
    BI_WAIT
  } bi_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_cmd_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating wait-phase counter.
// expired_o flags the last cycle a gnt/rvalid wait may last before it becomes an error.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Sticks at LAST so a long stall can never wrap back to a "fresh" count.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/bus_initiator.sv
// Turns one local read/write command into one req/gnt/rvalid bus transaction.
// A missing gnt or rvalid is converted into an error response by the timeout counter.
module bus_initiator
  import bus_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        req,
  output logic        we,
  output logic [3:0]  be,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        gnt,
  input  logic        rvalid,
  input  logic [31:0] rdata
);

  bi_state_e   state_q, state_d;
  bus_cmd_t    cmd_q, cmd_d;
  logic        req_q, req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        cnt_clear, cnt_en, expired;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .expired_o(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BI_IDLE;
      cmd_q       <= '0;
      req_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // A handshake beats expiry in the same cycle, in both wait phases.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BI_IDLE: if (cmd_valid) state_d = BI_REQ;
      BI_REQ: begin
        if (gnt) state_d = BI_WAIT;
        else if (expired) state_d = BI_IDLE;
      end
      BI_WAIT: if (rvalid || expired) state_d = BI_IDLE;
      default: state_d = BI_IDLE;
    endcase
  end

  always_comb begin
    cmd_d       = cmd_q;
    req_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    cnt_clear   = 1'b1;
    cnt_en      = 1'b0;
    unique case (state_q)
      BI_IDLE: begin
        if (cmd_valid) begin
          cmd_d = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata, be: cmd_be};
          req_d = 1'b1;
        end
      end
      BI_REQ: begin
        if (!gnt) begin
          if (expired) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            req_d     = 1'b1;
            cnt_clear = 1'b0;
            cnt_en    = 1'b1;
          end
        end
      end
      BI_WAIT: begin
        if (rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = cmd_q.we ? 32'h0 : rdata;
        end else if (expired) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_clear = 1'b0;
          cnt_en    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == BI_IDLE);
  assign req       = req_q;
  assign we        = cmd_q.we;
  assign be        = cmd_q.be;
  assign addr      = cmd_q.addr;
  assign wdata     = cmd_q.wdata;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Scoreboard bench for bus_initiator: a small decoder model answers the bus and
// monitors compare req pulses and responses against hand-computed expectations.
module tb_bus_initiator;

  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_be;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  typedef struct {int gntDelay; int rvalidDelay; logic [31:0] data;} busCfg_t;
  typedef struct {logic err; logic [31:0] rdata; int cycle; string name;} rspExp_t;
  typedef struct {int len; logic [31:0] addr; logic [4:0] weBe; logic [31:0] wdata; string name;} reqExp_t;

  busCfg_t cfgQ[$];
  rspExp_t rspQ[$];
  reqExp_t reqQ[$];

  int compared = 0;
  int mismatched = 0;
  int cycleCnt = 0;
  int modelRvalids = 0;

  bus_initiator #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk      (clock),
    .rst      (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_be   (cmd_be),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .req      (req),
    .we       (we),
    .be       (be),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [31:0] actual);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got 0x%08h, expected no such event", name, actual);
  endtask

  // Decoder model: gnt after gntDelay extra req cycles (never if negative), rvalid rvalidDelay cycles later.
  busCfg_t    cur;
  int         reqSeen = 0;
  int         pendCnt = 0;
  int         pendR = 1;
  logic       pending = 1'b0;
  logic [31:0] pendData = '0;

  initial begin
    gnt = 1'b0;
    rvalid = 1'b0;
    rdata = '0;
  end

  always @(negedge clock) begin
    rvalid = 1'b0;
    rdata = '0;
    if (pending) begin
      if (pendCnt >= pendR) begin
        rvalid = 1'b1;
        rdata = pendData;
        pending = 1'b0;
        modelRvalids++;
      end else begin
        pendCnt++;
      end
    end
    gnt = 1'b0;
    if (req === 1'b1) begin
      if (reqSeen == 0) begin
        if (cfgQ.size() > 0) cur = cfgQ.pop_front();
        else cur = '{-1, 1, 32'h0};
      end
      if (cur.gntDelay >= 0 && reqSeen == cur.gntDelay) begin
        gnt = 1'b1;
        pending = 1'b1;
        pendCnt = 1;
        pendR = cur.rvalidDelay;
        pendData = cur.data;
      end
      reqSeen++;
    end else begin
      reqSeen = 0;
    end
  end

  // Request monitor: length of each req pulse and stability of the bus fields while it is high.
  int        runLen = 0;
  logic      unstable = 1'b0;
  logic [68:0] firstCtl;
  reqExp_t   reqE;

  always @(negedge clock) begin
    if (req === 1'b1) begin
      if (runLen == 0) firstCtl = {we, be, addr, wdata};
      else if ({we, be, addr, wdata} !== firstCtl) unstable = 1'b1;
      runLen++;
    end else if (runLen > 0) begin
      if (reqQ.size() == 0) begin
        reportUnexpected("unexpected req pulse", runLen);
      end else begin
        reqE = reqQ.pop_front();
        checkOutput({reqE.name, " req length"}, runLen, reqE.len);
        checkOutput({reqE.name, " req addr"}, firstCtl[63:32], reqE.addr);
        checkOutput({reqE.name, " req we/be"}, {27'd0, firstCtl[68:64]}, {27'd0, reqE.weBe});
        checkOutput({reqE.name, " req wdata"}, firstCtl[31:0], reqE.wdata);
        checkOutput({reqE.name, " req stable"}, {31'd0, unstable}, 32'd0);
      end
      runLen = 0;
      unstable = 1'b0;
    end
  end

  // Response monitor.
  rspExp_t rspE;

  always @(negedge clock) begin
    if (rsp_valid === 1'b1) begin
      if (rspQ.size() == 0) begin
        reportUnexpected("unexpected rsp_valid", rsp_rdata);
      end else begin
        rspE = rspQ.pop_front();
        checkOutput({rspE.name, " rsp_err"}, {31'd0, rsp_err}, {31'd0, rspE.err});
        checkOutput({rspE.name, " rsp_rdata"}, rsp_rdata, rspE.rdata);
        checkOutput({rspE.name, " rsp cycle"}, cycleCnt, rspE.cycle);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge, cmd_valid still high.
  task automatic applyStimulus(input string name, input logic weV, input logic [31:0] addrV,
                               input logic [31:0] wdataV, input logic [3:0] beV, input int g,
                               input int r, input logic [31:0] data, input logic expErr,
                               input logic [31:0] expRdata, input bit expectRsp);
    int waited = 0;
    int a;
    cmd_valid = 1'b1;
    cmd_we = weV;
    cmd_addr = addrV;
    cmd_wdata = wdataV;
    cmd_be = beV;
    while (cmd_ready !== 1'b1 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      reportUnexpected({name, " accept timeout"}, waited);
      cmd_valid = 1'b0;
    end else begin
      a = cycleCnt;
      cfgQ.push_back('{g, r, data});
      reqQ.push_back('{(g < 0) ? TIMEOUT : g + 1, addrV, {weV, beV}, wdataV, name});
      if (expectRsp)
        rspQ.push_back('{expErr, expRdata, (g < 0) ? a + 1 + TIMEOUT : a + 2 + g + r, name});
      @(negedge clock);
    end
  endtask

  task automatic waitDrain(input string name);
    int waited = 0;
    while ((rspQ.size() != 0 || reqQ.size() != 0) && waited < 200) begin
      @(negedge clock);
      waited++;
    end
    if (rspQ.size() != 0 || reqQ.size() != 0)
      reportUnexpected({name, " drain timeout"}, rspQ.size() + reqQ.size());
    repeat (3) @(negedge clock);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    checkOutput({tag, " req"}, {31'd0, req}, 32'd0);
    checkOutput({tag, " we"}, {31'd0, we}, 32'd0);
    checkOutput({tag, " be"}, {28'd0, be}, 32'd0);
    checkOutput({tag, " addr"}, addr, 32'd0);
    checkOutput({tag, " wdata"}, wdata, 32'd0);
    checkOutput({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, " rsp_err"}, {31'd0, rsp_err}, 32'd0);
    checkOutput({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    cmd_be = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkResetState("reset");
    @(negedge clock);

    $display("[TB] write with immediate gnt");
    applyStimulus("t1 write", 1'b1, 32'h0000_0010, 32'h0000_00AA, 4'hF, 0, 1, 32'hDEAD_BEEF,
                  1'b0, 32'h0, 1'b1);
    cmd_valid = 1'b0;
    waitDrain("t1");

    $display("[TB] read with gnt delayed 3 cycles");
    applyStimulus("t2 read", 1'b0, 32'h0000_0104, 32'h0, 4'hF, 3, 2, 32'h1234_5678,
                  1'b0, 32'h1234_5678, 1'b1);
    cmd_valid = 1'b0;
    waitDrain("t2");

    $display("[TB] read of unmapped offset times out");
    applyStimulus("t3 timeout", 1'b0, 32'h0000_0FFC, 32'h0, 4'hF, -1, 1, 32'h0,
                  1'b1, 32'h0, 1'b1);
    cmd_valid = 1'b0;
    waitDrain("t3");

    $display("[TB] gnt in the expiry cycle");
    applyStimulus("t4 gnt at expiry", 1'b0, 32'h0000_0108, 32'h0, 4'h3, TIMEOUT - 1, 1,
                  32'h5A5A_0004, 1'b0, 32'h5A5A_0004, 1'b1);
    cmd_valid = 1'b0;
    waitDrain("t4");

    $display("[TB] reset asserted during WAIT");
    applyStimulus("t5 rst in wait", 1'b0, 32'h0000_0040, 32'h0, 4'hF, 0, 10, 32'hCAFE_0005,
                  1'b0, 32'h0, 1'b0);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("t5 in wait cmd_ready", {31'd0, cmd_ready}, 32'd0);
    #1 reset = 1'b1;
    #1 checkResetState("t5 mid-reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    checkOutput("t5 late rvalid delivered", modelRvalids, 32'd4);
    checkOutput("t5 idle after late rvalid", {31'd0, cmd_ready}, 32'd1);

    $display("[TB] three back-to-back reads");
    applyStimulus("t6 read0", 1'b0, 32'h0000_0020, 32'h0, 4'hF, 0, 1, 32'hB0B0_0001,
                  1'b0, 32'hB0B0_0001, 1'b1);
    applyStimulus("t6 read1", 1'b0, 32'h0000_0024, 32'h0, 4'hF, 0, 1, 32'hB0B0_0002,
                  1'b0, 32'hB0B0_0002, 1'b1);
    applyStimulus("t6 read2", 1'b0, 32'h0000_0028, 32'h0, 4'hF, 0, 1, 32'hB0B0_0003,
                  1'b0, 32'hB0B0_0003, 1'b1);
    cmd_valid = 1'b0;
    waitDrain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
